// File: rtl/exc_pkg.sv
// Shared types and constants for the exception controller: FSM states and ESR cause codes.
package exc_pkg;

   localparam int ESR_W = 4;

   typedef enum logic [1:0] {
      NORMAL  = 2'd0,
      HANDLER = 2'd1,
      HALT    = 2'd2
   } exc_state_t;

   localparam logic [ESR_W-1:0] ESR_NONE   = 4'd0;
   localparam logic [ESR_W-1:0] ESR_UNDEF  = 4'd1;
   localparam logic [ESR_W-1:0] ESR_IRQ    = 4'd2;
   localparam logic [ESR_W-1:0] ESR_ERET   = 4'd3;
   localparam logic [ESR_W-1:0] ESR_DFAULT = 4'd4;

   // True when a state change lands in an exception-taking state.
   function automatic logic enters_exception(exc_state_t cur, exc_state_t nxt);
      return (nxt != cur) && (nxt != NORMAL);
   endfunction

endpackage

// File: rtl/exc_ctrl_irq_sync.sv
// Two-flop synchroniser bringing the asynchronous external IRQ level into the clk domain.
module irq_sync (
   input  logic clk,
   input  logic reset,
   input  logic async_in,
   output logic sync_out
);

   logic meta_reg;
   logic sync_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_reg <= 1'b0;
         sync_reg <= 1'b0;
      end else begin
         meta_reg <= async_in;
         sync_reg <= meta_reg;
      end
   end

   assign sync_out = sync_reg;

endmodule

// File: rtl/exc_ctrl.sv
// Next-PC arbiter / exception controller feeding the fetch-stage PC mux.
// Define EXC_CNT_EN to build the 32-bit exceptions-taken counter; otherwise exc_count reads 0.
module exc_ctrl
   import exc_pkg::*;
#(
   parameter int          N          = 64,
   parameter logic [N-1:0] EXC_VECTOR = N'(64'hD8)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N-1:0]     pc_i,
   input  logic             branch_taken,
   input  logic [N-1:0]     branch_target,
   input  logic             invalid_instr,
   input  logic             eret,
   input  logic             ext_irq,
   output logic             PCSrc_F,
   output logic [N-1:0]     PCBranch_F,
   output logic             kill,
   output logic [N-1:0]     elr,
   output logic [ESR_W-1:0] esr,
   output logic             in_handler,
   output logic             halted,
   output logic [31:0]      exc_count
);

   exc_state_t       state_reg, state_next;
   logic [N-1:0]     elr_reg, elr_next;
   logic [ESR_W-1:0] esr_reg, esr_next;
   logic             irq_pend_reg, irq_pend_next;
   logic             irq_sync_s;
   logic             irq_take;

   irq_sync u_irq_sync (
      .clk      (clk),
      .reset    (reset),
      .async_in (ext_irq),
      .sync_out (irq_sync_s)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= NORMAL;
         elr_reg      <= '0;
         esr_reg      <= ESR_NONE;
         irq_pend_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         elr_reg      <= elr_next;
         esr_reg      <= esr_next;
         irq_pend_reg <= irq_pend_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      elr_next   = elr_reg;
      esr_next   = esr_reg;
      irq_take   = 1'b0;
      case (state_reg)
         NORMAL: begin
            if (invalid_instr) begin
               elr_next   = pc_i;
               esr_next   = ESR_UNDEF;
               state_next = HANDLER;
            end else if (eret) begin
               elr_next   = pc_i;
               esr_next   = ESR_ERET;
               state_next = HANDLER;
            end else if (irq_pend_reg) begin
               // The interrupted instruction retires, so return to its successor.
               elr_next   = branch_taken ? branch_target : pc_i + N'(4);
               esr_next   = ESR_IRQ;
               state_next = HANDLER;
               irq_take   = 1'b1;
            end
         end
         HANDLER: begin
            if (invalid_instr) begin
               esr_next   = ESR_DFAULT;
               state_next = HALT;
            end else if (eret) begin
               esr_next   = ESR_NONE;
               state_next = NORMAL;
            end
         end
         HALT: begin
            state_next = HALT;
         end
         default: begin
            state_next = NORMAL;
         end
      endcase
      irq_pend_next = irq_take ? 1'b0 : (irq_pend_reg | irq_sync_s);
   end

   always_comb begin
      PCSrc_F    = branch_taken;
      PCBranch_F = branch_target;
      kill       = 1'b0;
      case (state_reg)
         NORMAL: begin
            if (invalid_instr || eret) begin
               PCSrc_F    = 1'b1;
               PCBranch_F = EXC_VECTOR;
               kill       = 1'b1;
            end else if (irq_pend_reg) begin
               PCSrc_F    = 1'b1;
               PCBranch_F = EXC_VECTOR;
            end
         end
         HANDLER: begin
            if (invalid_instr) begin
               PCSrc_F    = 1'b1;
               PCBranch_F = pc_i;
               kill       = 1'b1;
            end else if (eret) begin
               PCSrc_F    = 1'b1;
               PCBranch_F = elr_reg;
            end
         end
         HALT: begin
            // Re-fetch the same PC forever and suppress every write.
            PCSrc_F    = 1'b1;
            PCBranch_F = pc_i;
            kill       = 1'b1;
         end
         default: begin
            PCSrc_F    = branch_taken;
            PCBranch_F = branch_target;
            kill       = 1'b0;
         end
      endcase
   end

   assign elr        = elr_reg;
   assign esr        = esr_reg;
   assign in_handler = (state_reg == HANDLER);
   assign halted     = (state_reg == HALT);

`ifdef EXC_CNT_EN
   logic [31:0] exc_count_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         exc_count_reg <= '0;
      end else if (enters_exception(state_reg, state_next)) begin
         exc_count_reg <= exc_count_reg + 32'd1;
      end
   end

   assign exc_count = exc_count_reg;
`else
   assign exc_count = '0;
`endif

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed table, multi-cycle sequences, randomized run vs. reference model.
module tb_exc_ctrl;

`ifdef EXC_CNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif
   localparam logic [63:0] VEC = 64'hD8;

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] pc_i;
   logic        branch_taken;
   logic [63:0] branch_target;
   logic        invalid_instr;
   logic        eret;
   logic        ext_irq;
   logic        PCSrc_F;
   logic [63:0] PCBranch_F;
   logic        kill;
   logic [63:0] elr;
   logic [3:0]  esr;
   logic        in_handler;
   logic        halted;
   logic [31:0] exc_count;

   int tests  = 0;
   int failed = 0;

   exc_ctrl dut (
      .clk           (clk),
      .reset         (reset),
      .pc_i          (pc_i),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .invalid_instr (invalid_instr),
      .eret          (eret),
      .ext_irq       (ext_irq),
      .PCSrc_F       (PCSrc_F),
      .PCBranch_F    (PCBranch_F),
      .kill          (kill),
      .elr           (elr),
      .esr           (esr),
      .in_handler    (in_handler),
      .halted        (halted),
      .exc_count     (exc_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] cnt_exp(input int n);
      return CNT_ON ? 64'(n) : 64'd0;
   endfunction

   task automatic drive(input logic [63:0] p, input logic i, input logic e,
                        input logic b, input logic [63:0] t);
      pc_i = p; invalid_instr = i; eret = e; branch_taken = b; branch_target = t;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      #2;
      reset = 1'b0;
   endtask

   // Single-cycle ext_irq pulse; afterwards the IRQ is pending (three edges later).
   task automatic pend_irq();
      drive(64'h0, 1'b0, 1'b0, 1'b0, 64'h0);
      ext_irq = 1'b1;
      tick();
      ext_irq = 1'b0;
      tick();
      #1;
      chk("irq_not_yet_pending", {63'd0, PCSrc_F}, 64'd0);
      tick();
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic [63:0] pc;
      logic        inv;
      logic        er;
      logic        bt;
      logic [63:0] tgt;
      logic        e_src;
      logic [63:0] e_pcb;
      logic        e_kill;
      logic [63:0] e_elr;
      logic [3:0]  e_esr;
      logic        e_hand;
      logic        e_halt;
      int          e_cnt;
   } vec_t;

   vec_t tbl [9];

   // ---------------- reference model ----------------
   typedef enum int {M_NORMAL, M_HANDLER, M_HALT} mode_t;
   mode_t       m_mode;
   logic [63:0] m_elr;
   logic [3:0]  m_esr;
   bit          m_pend;
   int          m_cnt;
   bit          m_hist [2];   // ext_irq seen at the last edge, and the edge before

   task automatic model_reset();
      m_mode = M_NORMAL; m_elr = '0; m_esr = '0; m_pend = 0; m_cnt = 0;
      m_hist[0] = 0; m_hist[1] = 0;
   endtask

   task automatic model_outputs(output logic src, output logic [63:0] pcb, output logic k);
      src = branch_taken; pcb = branch_target; k = 1'b0;
      if (m_mode == M_HALT) begin
         src = 1'b1; pcb = pc_i; k = 1'b1;
      end else if (m_mode == M_NORMAL) begin
         if (invalid_instr || eret) begin
            src = 1'b1; pcb = VEC; k = 1'b1;
         end else if (m_pend) begin
            src = 1'b1; pcb = VEC;
         end
      end else begin
         if (invalid_instr) begin
            src = 1'b1; pcb = pc_i; k = 1'b1;
         end else if (eret) begin
            src = 1'b1; pcb = m_elr;
         end
      end
   endtask

   task automatic model_edge();
      bit taken = 0;
      bit sync_now = m_hist[1];
      if (m_mode == M_NORMAL) begin
         if (invalid_instr) begin
            m_elr = pc_i; m_esr = 4'd1; m_mode = M_HANDLER; m_cnt++;
         end else if (eret) begin
            m_elr = pc_i; m_esr = 4'd3; m_mode = M_HANDLER; m_cnt++;
         end else if (m_pend) begin
            m_elr = branch_taken ? branch_target : pc_i + 64'd4;
            m_esr = 4'd2; m_mode = M_HANDLER; m_cnt++; taken = 1;
         end
      end else if (m_mode == M_HANDLER) begin
         if (invalid_instr) begin
            m_esr = 4'd4; m_mode = M_HALT; m_cnt++;
         end else if (eret) begin
            m_esr = 4'd0; m_mode = M_NORMAL;
         end
      end
      m_pend = taken ? 1'b0 : (m_pend | sync_now);
      m_hist[1] = m_hist[0];
      m_hist[0] = ext_irq;
   endtask

   initial begin
      logic        e_src, e_kill;
      logic [63:0] e_pcb;

      tbl[0] = '{64'h10, 1'b1, 1'b0, 1'b0, 64'h0,   1'b1, VEC,     1'b1, 64'h10, 4'd1, 1'b1, 1'b0, 1};
      tbl[1] = '{64'hD8, 1'b0, 1'b1, 1'b0, 64'h0,   1'b1, 64'h10,  1'b0, 64'h10, 4'd0, 1'b0, 1'b0, 1};
      tbl[2] = '{64'h10, 1'b0, 1'b0, 1'b1, 64'h30,  1'b1, 64'h30,  1'b0, 64'h10, 4'd0, 1'b0, 1'b0, 1};
      tbl[3] = '{64'h30, 1'b0, 1'b0, 1'b0, 64'h99,  1'b0, 64'h99,  1'b0, 64'h10, 4'd0, 1'b0, 1'b0, 1};
      tbl[4] = '{64'h34, 1'b0, 1'b1, 1'b0, 64'h0,   1'b1, VEC,     1'b1, 64'h34, 4'd3, 1'b1, 1'b0, 2};
      tbl[5] = '{64'hD8, 1'b0, 1'b0, 1'b1, 64'h100, 1'b1, 64'h100, 1'b0, 64'h34, 4'd3, 1'b1, 1'b0, 2};
      tbl[6] = '{64'hE0, 1'b1, 1'b0, 1'b0, 64'h0,   1'b1, 64'hE0,  1'b1, 64'h34, 4'd4, 1'b0, 1'b1, 3};
      tbl[7] = '{64'hE0, 1'b0, 1'b0, 1'b0, 64'h55,  1'b1, 64'hE0,  1'b1, 64'h34, 4'd4, 1'b0, 1'b1, 3};
      tbl[8] = '{64'hE4, 1'b0, 1'b1, 1'b1, 64'h77,  1'b1, 64'hE4,  1'b1, 64'h34, 4'd4, 1'b0, 1'b1, 3};

      // ---- power-on reset ----
      reset = 1'b1; ext_irq = 1'b0;
      drive(64'h0, 1'b0, 1'b0, 1'b0, 64'h0);
      tick(); tick();
      chk("rst_pcsrc", {63'd0, PCSrc_F}, 64'd0);
      chk("rst_kill", {63'd0, kill}, 64'd0);
      chk("rst_elr", elr, 64'd0);
      chk("rst_esr", {60'd0, esr}, 64'd0);
      chk("rst_state", {62'd0, in_handler, halted}, 64'd0);
      chk("rst_cnt", {32'd0, exc_count}, 64'd0);
      reset = 1'b0;
      tick();

      // ---- directed table ----
      for (int r = 0; r < 9; r++) begin
         drive(tbl[r].pc, tbl[r].inv, tbl[r].er, tbl[r].bt, tbl[r].tgt);
         #1;
         chk($sformatf("row%0d_pcsrc", r), {63'd0, PCSrc_F}, {63'd0, tbl[r].e_src});
         chk($sformatf("row%0d_pcbranch", r), PCBranch_F, tbl[r].e_pcb);
         chk($sformatf("row%0d_kill", r), {63'd0, kill}, {63'd0, tbl[r].e_kill});
         tick();
         chk($sformatf("row%0d_elr", r), elr, tbl[r].e_elr);
         chk($sformatf("row%0d_esr", r), {60'd0, esr}, {60'd0, tbl[r].e_esr});
         chk($sformatf("row%0d_mode", r), {62'd0, in_handler, halted},
             {62'd0, tbl[r].e_hand, tbl[r].e_halt});
         chk($sformatf("row%0d_cnt", r), {32'd0, exc_count}, cnt_exp(tbl[r].e_cnt));
         $display("[TB] row %0d pc=%h inv=%0b eret=%0b -> pcb=%h elr=%h esr=%0d",
                  r, tbl[r].pc, tbl[r].inv, tbl[r].er, PCBranch_F, elr, esr);
      end

      // ---- reset from HALT, asynchronous ----
      drive(64'hE8, 1'b0, 1'b0, 1'b0, 64'h0);
      #2;
      reset = 1'b1;
      #1;
      chk("midrst_halted", {63'd0, halted}, 64'd0);
      chk("midrst_elr", elr, 64'd0);
      chk("midrst_esr", {60'd0, esr}, 64'd0);
      chk("midrst_kill_src", {62'd0, kill, PCSrc_F}, 64'd0);
      reset = 1'b0;
      drive(64'h0, 1'b0, 1'b0, 1'b1, 64'h44);
      #1;
      chk("postrst_pass", {PCBranch_F[62:0], PCSrc_F}, {63'h44, 1'b1});
      $display("[TB] async reset from HALT");
      tick();

      // ---- IRQ while a branch is taken ----
      pulse_reset();
      pend_irq();
      drive(64'h40, 1'b0, 1'b0, 1'b1, 64'h80);
      #1;
      chk("irq_br_pcsrc", {63'd0, PCSrc_F}, 64'd1);
      chk("irq_br_pcb", PCBranch_F, VEC);
      chk("irq_br_kill", {63'd0, kill}, 64'd0);
      tick();
      chk("irq_br_elr", elr, 64'h80);
      chk("irq_br_esr", {60'd0, esr}, 64'd2);
      chk("irq_br_hand", {63'd0, in_handler}, 64'd1);
      drive(64'hD8, 1'b0, 1'b1, 1'b0, 64'h0);
      #1;
      chk("irq_ret_pcb", PCBranch_F, 64'h80);
      tick();
      chk("irq_ret_hand", {63'd0, in_handler}, 64'd0);
      $display("[TB] irq with branch: elr=%h", elr);

      // ---- fault and IRQ collide; IRQ taken right after ERET ----
      pulse_reset();
      pend_irq();
      drive(64'h20, 1'b1, 1'b0, 1'b0, 64'h0);
      #1;
      chk("col_kill", {63'd0, kill}, 64'd1);
      tick();
      chk("col_esr", {60'd0, esr}, 64'd1);
      chk("col_elr", elr, 64'h20);
      drive(64'hD8, 1'b0, 1'b1, 1'b0, 64'h0);
      #1;
      chk("col_ret_pcb", PCBranch_F, 64'h20);
      tick();
      chk("col_ret_esr", {60'd0, esr}, 64'd0);
      drive(64'h20, 1'b0, 1'b0, 1'b0, 64'h0);
      #1;
      chk("col_irq_src", {PCBranch_F[62:0], PCSrc_F, kill}, {VEC[62:0], 1'b1, 1'b0});
      tick();
      chk("col_irq_esr", {60'd0, esr}, 64'd2);
      chk("col_irq_elr", elr, 64'h24);
      chk("col_cnt", {32'd0, exc_count}, cnt_exp(2));
      $display("[TB] collision: esr=%0d elr=%h cnt=%0d", esr, elr, exc_count);

      // ---- pc+4 wraps at the top of the address space ----
      pulse_reset();
      pend_irq();
      drive(64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0, 1'b0, 64'h0);
      tick();
      chk("wrap_elr", elr, 64'h0);
      $display("[TB] wrap: elr=%h", elr);

      // ---- randomized run against the reference model ----
      pulse_reset();
      model_reset();
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 99) == 0 || (m_mode == M_HALT && $urandom_range(0, 7) == 0)) begin
            pulse_reset();
            model_reset();
         end
         drive({$urandom(), $urandom_range(0, 63), 2'b00},
               $urandom_range(0, 15) == 0, $urandom_range(0, 11) == 0,
               $urandom_range(0, 1) == 1, {$urandom(), $urandom()});
         if ($urandom_range(0, 9) == 0) ext_irq = ~ext_irq;
         #1;
         model_outputs(e_src, e_pcb, e_kill);
         chk("rnd_pcsrc", {63'd0, PCSrc_F}, {63'd0, e_src});
         chk("rnd_pcb", PCBranch_F, e_pcb);
         chk("rnd_kill", {63'd0, kill}, {63'd0, e_kill});
         chk("rnd_elr", elr, m_elr);
         chk("rnd_esr", {60'd0, esr}, {60'd0, m_esr});
         chk("rnd_mode", {62'd0, in_handler, halted},
             {62'd0, m_mode == M_HANDLER, m_mode == M_HALT});
         chk("rnd_cnt", {32'd0, exc_count}, cnt_exp(m_cnt));
         $display("[TB] rnd %0d pc=%h inv=%0b eret=%0b irq=%0b src=%0b pcb=%h kill=%0b esr=%0d",
                  c, pc_i, invalid_instr, eret, ext_irq, PCSrc_F, PCBranch_F, kill, esr);
         @(posedge clk);
         model_edge();
         #1;
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
